// File: rtl/stopwatch_ctl_pkg.sv
// Shared definitions for the stopwatch control FSM: state encoding and
// the {init_regs, count_enabled} output pairs.
package stopwatch_ctl_pkg;

  // 2-bit state; code 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_PAUSED   = 2'd0,
    ST_COUNTING = 2'd1,
    ST_IDLE     = 2'd2
  } state_t;

  // Output pairs, ordered {init_regs, count_enabled}.
  localparam logic [1:0] OUT_INIT  = 2'b10;
  localparam logic [1:0] OUT_COUNT = 2'b01;
  localparam logic [1:0] OUT_HOLD  = 2'b00;

endpackage

// File: rtl/stopwatch_ctl.sv
// Stopwatch control FSM (Mealy). Decodes start/pause (trig) and split/clear
// (split) pulses into counter clear and count-enable controls.
module stopwatch_ctl
  import stopwatch_ctl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic trig,
  input  logic split,
  output logic init_regs,
  output logic count_enabled
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_out;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and Mealy outputs; reset overrides everything, trig beats split.
  always_comb begin
    w_next = ST_IDLE;
    w_out  = OUT_INIT;
    if (reset) begin
      case (r_state)
        ST_IDLE: begin
          if (trig) begin
            w_next = ST_COUNTING;
            w_out  = OUT_COUNT;
          end else begin
            w_next = ST_IDLE;
            w_out  = OUT_INIT;
          end
        end
        ST_COUNTING: begin
          if (trig) begin
            w_next = ST_PAUSED;
            w_out  = OUT_HOLD;
          end else begin
            w_next = ST_COUNTING;
            w_out  = OUT_COUNT;
          end
        end
        ST_PAUSED: begin
          if (trig) begin
            w_next = ST_COUNTING;
            w_out  = OUT_COUNT;
          end else if (split) begin
            // Clear is deferred to the IDLE cycle that follows.
            w_next = ST_IDLE;
            w_out  = OUT_HOLD;
          end else begin
            w_next = ST_PAUSED;
            w_out  = OUT_HOLD;
          end
        end
        default: begin
          w_next = ST_IDLE;
          w_out  = OUT_INIT;
        end
      endcase
    end
  end

  assign init_regs     = w_out[1];
  assign count_enabled = w_out[0];

endmodule

// File: tb/tb_stopwatch_ctl.sv
// Self-checking bench for stopwatch_ctl: directed scenarios followed by
// randomized pulses, compared against a behavioural stopwatch model.
module tb_stopwatch_ctl;
  import stopwatch_ctl_pkg::*;

  logic clk;
  logic reset;
  logic trig;
  logic split;
  logic init_regs;
  logic count_enabled;

  int unsigned n_total;
  int unsigned n_bad;

  // Model mode of the stopwatch: what the user would see.
  typedef enum int { M_CLEARED, M_RUNNING, M_FROZEN, M_CORRUPT } mode_t;
  mode_t m_mode;

  stopwatch_ctl dut (
    .clk           (clk),
    .reset         (reset),
    .trig          (trig),
    .split         (split),
    .init_regs     (init_regs),
    .count_enabled (count_enabled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural rules: what the datapath should do this cycle and what
  // the stopwatch becomes afterwards.
  task automatic model(input logic rst, input logic t, input logic s,
                       output logic [1:0] exp, output mode_t nxt);
    if (!rst || m_mode == M_CORRUPT) begin
      exp = 2'b10; nxt = M_CLEARED;
    end else if (m_mode == M_CLEARED) begin
      if (t) begin exp = 2'b01; nxt = M_RUNNING; end
      else   begin exp = 2'b10; nxt = M_CLEARED; end
    end else if (m_mode == M_RUNNING) begin
      if (t) begin exp = 2'b00; nxt = M_FROZEN; end
      else   begin exp = 2'b01; nxt = M_RUNNING; end
    end else begin
      if (t)      begin exp = 2'b01; nxt = M_RUNNING; end
      else if (s) begin exp = 2'b00; nxt = M_CLEARED; end
      else        begin exp = 2'b00; nxt = M_FROZEN; end
    end
  endtask

  // One clock cycle: drive at the falling edge, check mid-low-phase,
  // advance the model at the rising edge.
  task automatic step(input string tag, input logic rst, input logic t, input logic s);
    logic [1:0] exp;
    mode_t      nxt;
    @(negedge clk);
    reset = rst; trig = t; split = s;
    #2;
    model(rst, t, s, exp, nxt);
    check(tag, {init_regs, count_enabled}, exp);
    @(posedge clk);
    m_mode = nxt;
  endtask

  task automatic illegal_step();
    logic [1:0] exp;
    mode_t      nxt;
    @(negedge clk);
    reset = 1'b1; trig = 1'b0; split = 1'b0;
    force dut.r_state = state_t'(2'b11);
    m_mode = M_CORRUPT;
    #2;
    model(1'b1, 1'b0, 1'b0, exp, nxt);
    check("illegal_out", {init_regs, count_enabled}, exp);
    release dut.r_state;
    @(posedge clk);
    m_mode = nxt;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    m_mode  = M_CLEARED;
    reset = 1'b0; trig = 1'b0; split = 1'b0;

    // Reset held two edges with trig high.
    step("rst_trig0", 1'b0, 1'b1, 1'b0);
    step("rst_trig1", 1'b0, 1'b1, 1'b0);
    step("idle_after_rst", 1'b1, 1'b0, 1'b0);

    // Start / pause / resume.
    step("start", 1'b1, 1'b1, 1'b0);
    step("counting", 1'b1, 1'b0, 1'b0);
    step("pause", 1'b1, 1'b1, 1'b0);
    step("paused", 1'b1, 1'b0, 1'b0);
    step("resume", 1'b1, 1'b1, 1'b0);
    step("split_in_count", 1'b1, 1'b0, 1'b1);
    step("still_count", 1'b1, 1'b0, 1'b0);

    // Split from PAUSED clears on the following IDLE cycle.
    step("pause2", 1'b1, 1'b1, 1'b0);
    step("split_paused", 1'b1, 1'b0, 1'b1);
    step("idle_after_split", 1'b1, 1'b0, 1'b0);
    step("split_in_idle", 1'b1, 1'b0, 1'b1);
    step("idle_hold", 1'b1, 1'b0, 1'b0);

    // Priority: trig over split in PAUSED, reset over trig in COUNTING.
    step("start2", 1'b1, 1'b1, 1'b0);
    step("pause3", 1'b1, 1'b1, 1'b0);
    step("trig_and_split", 1'b1, 1'b1, 1'b1);
    step("count_after_both", 1'b1, 1'b0, 1'b0);
    step("rst_over_trig", 1'b0, 1'b1, 1'b0);
    step("idle_after_rst2", 1'b1, 1'b0, 1'b0);
    step("restart", 1'b1, 1'b1, 1'b0);
    step("recount", 1'b1, 1'b0, 1'b0);

    // Held trig toggles every cycle.
    for (int unsigned i = 0; i < 4; i++) step("held_trig", 1'b1, 1'b1, 1'b0);

    // Illegal state recovery.
    illegal_step();
    step("idle_after_illegal", 1'b1, 1'b0, 1'b0);
    step("start_after_illegal", 1'b1, 1'b1, 1'b0);

    // Randomized pulses with occasional reset.
    for (int unsigned i = 0; i < 400; i++) begin
      step("random",
           ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
